// File: rtl/vip_axi4_rd_responder.sv
// Behavioural AXI4 read-slave responder: queues AR requests and returns R bursts
// whose data is the beat byte address, with FIXED/INCR/WRAP beat addressing.
module vip_axi4_rd_responder #(
  parameter int unsigned            ID_WIDTH_P      = 4,
  parameter int unsigned            ADDR_WIDTH_P    = 32,
  parameter int unsigned            DATA_WIDTH_P    = 64,
  parameter int unsigned            USER_WIDTH_P    = 1,
  parameter int unsigned            AR_FIFO_DEPTH_P = 4,
  parameter logic [ADDR_WIDTH_P-1:0] ADDR_LIMIT_P   = 'h0001_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH_P-1:0]   arid,
  input  logic [ADDR_WIDTH_P-1:0] araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic [USER_WIDTH_P-1:0] aruser,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH_P-1:0]   rid,
  output logic [DATA_WIDTH_P-1:0] rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic [USER_WIDTH_P-1:0] ruser,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned PTR_W = $clog2(AR_FIFO_DEPTH_P);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(AR_FIFO_DEPTH_P);

  typedef struct packed {
    logic [ID_WIDTH_P-1:0]   id;
    logic [ADDR_WIDTH_P-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [USER_WIDTH_P-1:0] user;
  } arEntry_t;

  typedef enum logic {IDLE, BURST} state_t;

  arEntry_t          fifo_q [AR_FIFO_DEPTH_P];
  logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
  logic [PTR_W:0]    count_q;
  logic              live_q;
  arEntry_t          head;
  logic              push, pop;

  state_t                  state_q;
  logic [ADDR_WIDTH_P-1:0] startAddr_q, curAddr_q;
  logic [7:0]              len_q, beatCnt_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    rvalid_q, rlast_q;
  logic [1:0]              rresp_q;
  logic [ID_WIDTH_P-1:0]   rid_q;
  logic [USER_WIDTH_P-1:0] ruser_q;
  logic [DATA_WIDTH_P-1:0] rdata_q;

  logic [ADDR_WIDTH_P-1:0] bytes, wrapTotal, wrapLower, nextAddr_d;
  logic                    nextLast_d;

  function automatic logic [1:0] respFor(input logic [ADDR_WIDTH_P-1:0] a,
                                         input logic [1:0] b);
    return ((a >= ADDR_LIMIT_P) || (b == 2'b11)) ? 2'b10 : 2'b00;
  endfunction

  assign head    = fifo_q[rdPtr_q];
  assign arready = live_q && (count_q != FULL_COUNT);
  assign push    = arvalid && arready;
  assign pop     = (state_q == IDLE) && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wrPtr_q] <= '{id: arid, addr: araddr, len: arlen, size: arsize,
                           burst: arburst, user: aruser};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      live_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // WRAP bounds come from the start address; lengths that are not a power of
  // two are deliberately processed with the same masking arithmetic.
  always_comb begin
    bytes      = ADDR_WIDTH_P'(1) << size_q;
    wrapTotal  = (ADDR_WIDTH_P'(len_q) + ADDR_WIDTH_P'(1)) << size_q;
    wrapLower  = startAddr_q & ~(wrapTotal - ADDR_WIDTH_P'(1));
    nextLast_d = ((beatCnt_q + 8'd1) == len_q);
    case (burst_q)
      2'b01:   nextAddr_d = (curAddr_q & ~(bytes - ADDR_WIDTH_P'(1))) + bytes;
      2'b10:   nextAddr_d = wrapLower +
                            ((curAddr_q + bytes - wrapLower) & (wrapTotal - ADDR_WIDTH_P'(1)));
      default: nextAddr_d = curAddr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      startAddr_q <= '0;
      curAddr_q   <= '0;
      len_q       <= '0;
      beatCnt_q   <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rresp_q     <= 2'b00;
      rid_q       <= '0;
      ruser_q     <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            startAddr_q <= head.addr;
            curAddr_q   <= head.addr;
            len_q       <= head.len;
            size_q      <= head.size;
            burst_q     <= head.burst;
            beatCnt_q   <= 8'd0;
            rid_q       <= head.id;
            ruser_q     <= head.user;
            rdata_q     <= DATA_WIDTH_P'(head.addr);
            rresp_q     <= respFor(head.addr, head.burst);
            rlast_q     <= (head.len == 8'd0);
            rvalid_q    <= 1'b1;
            state_q     <= BURST;
          end
        end
        BURST: begin
          if (rready) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state_q  <= IDLE;
            end else begin
              curAddr_q <= nextAddr_d;
              beatCnt_q <= beatCnt_q + 8'd1;
              rdata_q   <= DATA_WIDTH_P'(nextAddr_d);
              rresp_q   <= respFor(nextAddr_d, burst_q);
              rlast_q   <= nextLast_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rvalid = rvalid_q;
  assign rlast  = rlast_q;
  assign rresp  = rresp_q;
  assign rid    = rid_q;
  assign ruser  = ruser_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_vip_axi4_rd_responder.sv
// Bench for vip_axi4_rd_responder: directed and randomized AR traffic checked
// beat-by-beat against a burst-level address model.
module tb_vip_axi4_rd_responder;

  localparam logic [31:0] LIMIT = 32'h0001_0000;

  logic        clk;
  logic        rst_n;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        aruser;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        ruser;
  logic        rvalid;
  logic        rready;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } beat_t;

  beat_t expQ[$];
  int    checksTotal  = 0;
  int    checksPassed = 0;
  bit    randReady    = 0;
  bit    expectBubble = 0;

  vip_axi4_rd_responder dut (
    .clk(clk), .rst_n(rst_n),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .aruser(aruser), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
    .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checksTotal++;
    assert (obs === exp) checksPassed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    if (randReady) rready = ($urandom_range(0, 3) != 0);
  endtask

  // Expected beats derived from the AR fields alone.
  task automatic pushBurst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic user);
    logic [31:0] bytes, total, lower, a;
    beat_t b;
    bytes = 32'd1 << size;
    total = (32'(len) + 32'd1) * bytes;
    lower = addr & ~(total - 32'd1);
    a     = addr;
    for (int n = 0; n <= int'(len); n++) begin
      if (burst == 2'b01)
        a = (n == 0) ? addr : (addr & ~(bytes - 32'd1)) + 32'(n) * bytes;
      else if (burst == 2'b10)
        a = (n == 0) ? addr : lower + ((a + bytes - lower) & (total - 32'd1));
      else
        a = addr;
      b.id   = id;
      b.addr = a;
      b.resp = ((a >= LIMIT) || (burst == 2'b11)) ? 2'b10 : 2'b00;
      b.last = (n == int'(len));
      b.user = user;
      expQ.push_back(b);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic user);
    int waitCnt;
    waitCnt = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; aruser = user;
    arvalid = 1'b1;
    while (!arready && waitCnt < 300) begin
      step();
      waitCnt++;
    end
    checkVal("arAccept", {63'b0, arready}, 64'd1);
    if (arready) begin
      pushBurst(id, addr, len, size, burst, user);
      step();
    end
    arvalid = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while ((expQ.size() != 0 || rvalid) && n < maxCycles) begin
      step();
      n++;
    end
    checkVal("drainDone", {63'b0, (expQ.size() == 0 && !rvalid)}, 64'd1);
  endtask

  // Beat monitor: every R handshake is compared with the head of the model queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      expectBubble = 0;
    end else begin
      if (expectBubble) begin
        checkVal("bubble", {63'b0, rvalid}, 64'd0);
        expectBubble = 0;
      end
      if (rvalid && rready) begin
        checkVal("beatExpected", {63'b0, (expQ.size() != 0)}, 64'd1);
        if (expQ.size() != 0) begin
          checkVal("rid",   {60'b0, rid},   {60'b0, expQ[0].id});
          checkVal("rdata", rdata,          {32'b0, expQ[0].addr});
          checkVal("rresp", {62'b0, rresp}, {62'b0, expQ[0].resp});
          checkVal("rlast", {63'b0, rlast}, {63'b0, expQ[0].last});
          checkVal("ruser", {63'b0, ruser}, {63'b0, expQ[0].user});
          expectBubble = expQ[0].last;
          void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; arvalid = 1'b0; rready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; aruser = 1'b0;
    step();
    step();
    checkVal("rstArready", {63'b0, arready}, 64'd0);
    checkVal("rstRvalid",  {63'b0, rvalid},  64'd0);
    checkVal("rstRlast",   {63'b0, rlast},   64'd0);
    checkVal("rstRresp",   {62'b0, rresp},   64'd0);
    checkVal("rstRid",     {60'b0, rid},     64'd0);
    checkVal("rstRdata",   rdata,            64'd0);
    checkVal("rstRuser",   {63'b0, ruser},   64'd0);
    rst_n = 1'b1;
    step();
    checkVal("arreadyAfterRst", {63'b0, arready}, 64'd1);

    // INCR with first-beat latency
    rready = 1'b1;
    applyStimulus(4'd3, 32'h100, 8'd3, 3'd3, 2'b01, 1'b0);
    checkVal("latencyEarly", {63'b0, rvalid}, 64'd0);
    step();
    checkVal("latencyFirst", {63'b0, rvalid}, 64'd1);
    waitDrain(50);

    // WRAP, unaligned INCR, FIXED, reserved burst, error boundary
    applyStimulus(4'd5, 32'h1C, 8'd3, 3'd2, 2'b10, 1'b1);
    applyStimulus(4'd6, 32'h103, 8'd1, 3'd2, 2'b01, 1'b0);
    applyStimulus(4'd7, 32'h40, 8'd2, 3'd3, 2'b00, 1'b0);
    applyStimulus(4'd8, 32'h80, 8'd1, 3'd3, 2'b11, 1'b1);
    applyStimulus(4'd9, LIMIT - 32'd8, 8'd1, 3'd3, 2'b01, 1'b0);
    waitDrain(200);

    // Backpressure and queue full
    rready = 1'b0;
    for (int i = 0; i < 5; i++)
      applyStimulus(4'(i), 32'h200 + 32'(i * 'h40), 8'd1, 3'd3, 2'b01, 1'b0);
    arid = 4'hA; araddr = 32'h400; arlen = 8'd2; arsize = 3'd2; arburst = 2'b01; aruser = 1'b1;
    arvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checkVal("fullArready", {63'b0, arready}, 64'd0);
      checkVal("holdRvalid",  {63'b0, rvalid},  64'd1);
      checkVal("holdRdata",   rdata,            {32'b0, expQ[0].addr});
      checkVal("holdRid",     {60'b0, rid},     {60'b0, expQ[0].id});
    end
    rready = 1'b1;
    applyStimulus(4'hA, 32'h400, 8'd2, 3'd2, 2'b01, 1'b1);
    waitDrain(400);

    // Reset mid-burst with two requests queued
    applyStimulus(4'd1, 32'h800, 8'd7, 3'd3, 2'b01, 1'b0);
    applyStimulus(4'd2, 32'h900, 8'd1, 3'd3, 2'b01, 1'b0);
    applyStimulus(4'd4, 32'hA00, 8'd1, 3'd3, 2'b01, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    checkVal("midRstRvalid",  {63'b0, rvalid},  64'd0);
    checkVal("midRstArready", {63'b0, arready}, 64'd0);
    checkVal("midRstRlast",   {63'b0, rlast},   64'd0);
    checkVal("midRstRdata",   rdata,            64'd0);
    step();
    rst_n = 1'b1;
    expQ.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      checkVal("noStaleBeat", {63'b0, rvalid}, 64'd0);
    end
    checkVal("arreadyAfterMidRst", {63'b0, arready}, 64'd1);
    applyStimulus(4'hC, 32'h300, 8'd1, 3'd3, 2'b01, 1'b1);
    waitDrain(50);

    // Randomized traffic with random backpressure
    randReady = 1;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(4'($urandom_range(0, 15)),
                    ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 'hFFF))
                                                : LIMIT - 32'($urandom_range(0, 'h40)),
                    8'($urandom_range(0, 7)), 3'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    waitDrain(2000);
    randReady = 0;

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
